// File: rtl/eth_frame_tx.sv
// Ethernet II frame builder: header + payload + zero pad to MIN_FRAME_LEN, FCS left to the MAC.
// Optional inter-frame gap hold-off enabled by defining FRAME_TX_IFG_EN.
module eth_frame_tx #(
  parameter logic [47:0] LOCAL_MAC     = 48'h00_0A_35_00_01_02,
  parameter int          MIN_FRAME_LEN = 60
`ifdef FRAME_TX_IFG_EN
  ,
  parameter int          IFG_CYCLES    = 12
`endif
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic [47:0] hdr_dst_mac_in,
  input  logic [15:0] hdr_type_in,
  input  logic        hdr_valid_in,
  output logic        hdr_ready_out,
  input  logic [7:0]  pay_tdata_in,
  input  logic        pay_tvalid_in,
  output logic        pay_tready_out,
  input  logic        pay_tlast_in,
  output logic [7:0]  mac_tdata_out,
  output logic        mac_tvalid_out,
  input  logic        mac_tready_in,
  output logic        mac_tlast_out,
  output logic        frame_busy_out
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PAD,
    DONE,
    IFG
  } state_t;

  state_t      state;
  logic [10:0] cnt;
  logic [47:0] dst_mac;
  logic [15:0] eth_type;

`ifdef FRAME_TX_IFG_EN
  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  logic [IFG_W-1:0] ifg_cnt;
`endif

  logic        mac_fire;
  logic [11:0] cnt_plus_one;
  logic        len_ok;
  logic        pad_last;
  logic [7:0]  hdr_byte;

  assign mac_fire     = mac_tvalid_out && mac_tready_in;
  assign cnt_plus_one = {1'b0, cnt} + 12'd1;
  assign len_ok       = cnt_plus_one >= 12'(MIN_FRAME_LEN);
  assign pad_last     = cnt == 11'(MIN_FRAME_LEN - 1);

  // Header byte selection; the counter doubles as the header byte index.
  always_comb begin
    hdr_byte = 8'h00;
    case (cnt[3:0])
      4'd0:  hdr_byte = dst_mac[47:40];
      4'd1:  hdr_byte = dst_mac[39:32];
      4'd2:  hdr_byte = dst_mac[31:24];
      4'd3:  hdr_byte = dst_mac[23:16];
      4'd4:  hdr_byte = dst_mac[15:8];
      4'd5:  hdr_byte = dst_mac[7:0];
      4'd6:  hdr_byte = LOCAL_MAC[47:40];
      4'd7:  hdr_byte = LOCAL_MAC[39:32];
      4'd8:  hdr_byte = LOCAL_MAC[31:24];
      4'd9:  hdr_byte = LOCAL_MAC[23:16];
      4'd10: hdr_byte = LOCAL_MAC[15:8];
      4'd11: hdr_byte = LOCAL_MAC[7:0];
      4'd12: hdr_byte = eth_type[15:8];
      4'd13: hdr_byte = eth_type[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Outputs decode from registered state; PAYLOAD is a straight pass-through.
  always_comb begin
    hdr_ready_out  = 1'b0;
    pay_tready_out = 1'b0;
    mac_tvalid_out = 1'b0;
    mac_tlast_out  = 1'b0;
    mac_tdata_out  = 8'h00;
    frame_busy_out = 1'b0;
    case (state)
      IDLE: hdr_ready_out = 1'b1;
      HEADER: begin
        mac_tvalid_out = 1'b1;
        mac_tdata_out  = hdr_byte;
        frame_busy_out = 1'b1;
      end
      PAYLOAD: begin
        mac_tvalid_out = pay_tvalid_in;
        mac_tdata_out  = pay_tdata_in;
        mac_tlast_out  = pay_tlast_in && len_ok;
        pay_tready_out = mac_tready_in;
        frame_busy_out = 1'b1;
      end
      PAD: begin
        mac_tvalid_out = 1'b1;
        mac_tlast_out  = pad_last;
        frame_busy_out = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state    <= IDLE;
      cnt      <= 11'd0;
      dst_mac  <= 48'h0;
      eth_type <= 16'h0;
`ifdef FRAME_TX_IFG_EN
      ifg_cnt  <= '0;
`endif
    end else begin
      if (mac_fire && cnt != 11'h7FF)
        cnt <= cnt + 11'd1;
      case (state)
        IDLE: begin
          if (hdr_valid_in) begin
            dst_mac  <= hdr_dst_mac_in;
            eth_type <= hdr_type_in;
            cnt      <= 11'd0;
            state    <= HEADER;
          end
        end
        HEADER: begin
          if (mac_fire && cnt == 11'd13)
            state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (mac_fire && pay_tlast_in)
            state <= len_ok ? DONE : PAD;
        end
        PAD: begin
          if (mac_fire && pad_last)
            state <= DONE;
        end
        DONE: begin
`ifdef FRAME_TX_IFG_EN
          ifg_cnt <= IFG_W'(IFG_CYCLES - 1);
          state   <= IFG;
`else
          state   <= IDLE;
`endif
        end
`ifdef FRAME_TX_IFG_EN
        IFG: begin
          if (ifg_cnt == '0)
            state <= IDLE;
          else
            ifg_cnt <= ifg_cnt - 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed self-checking bench for eth_frame_tx: padded, unpadded, stalled,
// reset-aborted and back-to-back frames with hand-built expected byte streams.
module tb_eth_frame_tx;

`ifdef FRAME_TX_IFG_EN
  localparam int EXP_GAP = 14;
`else
  localparam int EXP_GAP = 2;
`endif

  logic        logic_clk = 1'b0;
  logic        logic_rst;
  logic [47:0] hdr_dst_mac_in;
  logic [15:0] hdr_type_in;
  logic        hdr_valid_in;
  logic        hdr_ready_out;
  logic [7:0]  pay_tdata_in;
  logic        pay_tvalid_in;
  logic        pay_tready_out;
  logic        pay_tlast_in;
  logic [7:0]  mac_tdata_out;
  logic        mac_tvalid_out;
  logic        mac_tready_in;
  logic        mac_tlast_out;
  logic        frame_busy_out;

  int checks   = 0;
  int failures = 0;

  always #5 logic_clk = ~logic_clk;

  eth_frame_tx dut (
    .logic_clk      (logic_clk),
    .logic_rst      (logic_rst),
    .hdr_dst_mac_in (hdr_dst_mac_in),
    .hdr_type_in    (hdr_type_in),
    .hdr_valid_in   (hdr_valid_in),
    .hdr_ready_out  (hdr_ready_out),
    .pay_tdata_in   (pay_tdata_in),
    .pay_tvalid_in  (pay_tvalid_in),
    .pay_tready_out (pay_tready_out),
    .pay_tlast_in   (pay_tlast_in),
    .mac_tdata_out  (mac_tdata_out),
    .mac_tvalid_out (mac_tvalid_out),
    .mac_tready_in  (mac_tready_in),
    .mac_tlast_out  (mac_tlast_out),
    .frame_busy_out (frame_busy_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Runs one frame; abort_at >= 0 pulses reset when that frame byte is due.
  task automatic applyStimulus(input logic [47:0] dst, input logic [15:0] etype, input int len,
                               input bit rand_ready, input int abort_at, input bit check_gap);
    byte unsigned exp_q[$];
    logic [47:0] src = 48'h00_0A_35_00_01_02;
    bit   accepted = 0, after_accept = 0, done = 0, aborted = 0, stalled_prev = 0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    int   p = 0, k = 0, cycles = 0, n = 0;

    for (int i = 0; i < 6; i++) exp_q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(src[47-8*i -: 8]);
    exp_q.push_back(etype[15:8]);
    exp_q.push_back(etype[7:0]);
    for (int i = 0; i < len; i++) exp_q.push_back(8'((i + 1) & 255));
    while (exp_q.size() < 60) exp_q.push_back(8'h00);

    while (!done && cycles < 3000) begin
      @(negedge logic_clk);
      hdr_dst_mac_in = dst;
      hdr_type_in    = etype;
      hdr_valid_in   = !accepted;
      pay_tvalid_in  = (p < len);
      pay_tdata_in   = 8'((p + 1) & 255);
      pay_tlast_in   = (p == len - 1);
      mac_tready_in  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at >= 0 && accepted && k == abort_at) begin
        logic_rst = 1'b1;
        @(negedge logic_clk);
        logic_rst     = 1'b0;
        hdr_valid_in  = 1'b0;
        pay_tvalid_in = 1'b0;
        #1;
        checkOutput("rst_mid_tvalid", mac_tvalid_out, 0);
        checkOutput("rst_mid_hdr_ready", hdr_ready_out, 1);
        checkOutput("rst_mid_busy", frame_busy_out, 0);
        aborted = 1;
        done    = 1;
      end else begin
        #1;
        if (!accepted) begin
          checkOutput("pre_hdr_pay_stall", pay_tready_out, 0);
          if (hdr_ready_out) begin
            accepted     = 1;
            after_accept = 1;
          end
        end else begin
          if (after_accept) begin
            checkOutput("hdr0_latency", mac_tvalid_out, 1);
            after_accept = 0;
          end
          checkOutput("busy_in_frame", frame_busy_out, 1);
          checkOutput("hdr_ready_in_frame", hdr_ready_out, 0);
          if (stalled_prev) begin
            checkOutput("stall_valid", mac_tvalid_out, 1);
            checkOutput("stall_data", mac_tdata_out, prev_data);
            checkOutput("stall_last", mac_tlast_out, prev_last);
          end
          if (k >= 14 && p < len)
            checkOutput("pay_tready_track", pay_tready_out, mac_tready_in);
          else
            checkOutput("pay_tready_low", pay_tready_out, 0);
          if (mac_tvalid_out && mac_tready_in) begin
            if (k < exp_q.size())
              checkOutput($sformatf("byte%0d", k), mac_tdata_out, exp_q[k]);
            checkOutput($sformatf("tlast%0d", k), mac_tlast_out, (k == exp_q.size() - 1));
            done = (k == exp_q.size() - 1) || mac_tlast_out;
            k++;
          end
          stalled_prev = mac_tvalid_out && !mac_tready_in;
          prev_data    = mac_tdata_out;
          prev_last    = mac_tlast_out;
          if (pay_tvalid_in && pay_tready_out) p++;
        end
      end
      cycles++;
    end

    if (!done) checkOutput("frame_timeout", 1, 0);
    if (!aborted) begin
      checkOutput("frame_len", k, exp_q.size());
      checkOutput("pay_consumed", p, len);
    end

    if (check_gap && !aborted) begin
      n = 0;
      while (n < 40) begin
        @(negedge logic_clk);
        hdr_valid_in  = 1'b0;
        pay_tvalid_in = 1'b0;
        pay_tlast_in  = 1'b0;
        mac_tready_in = 1'b1;
        #1;
        n++;
        if (n == 1) begin
          checkOutput("done_tvalid", mac_tvalid_out, 0);
          checkOutput("done_busy", frame_busy_out, 0);
        end
        if (hdr_ready_out) break;
      end
      checkOutput("frame_gap", n, EXP_GAP);
    end
  endtask

  initial begin
    logic_rst      = 1'b1;
    hdr_dst_mac_in = 48'h0;
    hdr_type_in    = 16'h0;
    hdr_valid_in   = 1'b0;
    pay_tdata_in   = 8'h00;
    pay_tvalid_in  = 1'b0;
    pay_tlast_in   = 1'b0;
    mac_tready_in  = 1'b1;
    repeat (3) @(negedge logic_clk);
    #1;
    checkOutput("rst_hdr_ready", hdr_ready_out, 1);
    checkOutput("rst_pay_tready", pay_tready_out, 0);
    checkOutput("rst_tvalid", mac_tvalid_out, 0);
    checkOutput("rst_tlast", mac_tlast_out, 0);
    checkOutput("rst_tdata", mac_tdata_out, 0);
    checkOutput("rst_busy", frame_busy_out, 0);
    logic_rst = 1'b0;

    $display("[TB] padded 28-byte ARP frame");
    applyStimulus(48'hFFFF_FFFF_FFFF, 16'h0806, 28, 1'b0, -1, 1'b1);
    $display("[TB] 100-byte IPv4 frame, no pad");
    applyStimulus(48'h0011_2233_4455, 16'h0800, 100, 1'b0, -1, 1'b1);
    $display("[TB] 28-byte frame with random MAC backpressure");
    applyStimulus(48'hFFFF_FFFF_FFFF, 16'h0806, 28, 1'b1, -1, 1'b1);
    $display("[TB] reset during payload");
    applyStimulus(48'h0A0B_0C0D_0E0F, 16'h0800, 40, 1'b0, 24, 1'b0);
    $display("[TB] frame after reset");
    applyStimulus(48'h0A0B_0C0D_0E0F, 16'h0806, 28, 1'b0, -1, 1'b1);
    $display("[TB] exact 46-byte payload");
    applyStimulus(48'h1234_5678_9ABC, 16'h86DD, 46, 1'b0, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
